me_mem: RTL and testbench

Pixel-memory front end for the motion estimation core `me`. It accepts the current 16×16 macroblock and the 48×48 search window as one raster pixel stream and writes them into column-banked storage. It then answers the `me` read interface (`addr`, `amt` → `pixel_cpr_in`, `pixel_spr_in`) combinationally, with the bank rotation `me` expects. The block sits between the frame-buffer fetch logic and `me`.

---
 rtl/me_mem_if.sv | 25 ++
 rtl/me_mem.sv | 109 ++++++++++
 tb/tb_me_mem.sv | 135 +++++++++++++
 3 files changed

// File: rtl/me_mem_if.sv
// me_mem_if: load stream and `me` read port between the fetch logic, me_mem and `me`.
interface me_mem_if #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
);
    localparam int PORT_WIDTH = MACRO_DIM + 1;
    logic                        start_load;
    logic [7:0]                  pixel_in;
    logic                        pixel_valid;
    logic                        pixel_ready;
    logic                        loaded;
    logic                        load_done;
    logic [5:0]                  addr;
    logic [5:0]                  amt;
    logic [MACRO_DIM-1:0][7:0]   pixel_cpr_out;
    logic [PORT_WIDTH-1:0][7:0]  pixel_spr_out;
    modport master (
        output start_load, pixel_in, pixel_valid, addr, amt,
        input  pixel_ready, loaded, load_done, pixel_cpr_out, pixel_spr_out
    );
    modport slave (
        input  start_load, pixel_in, pixel_valid, addr, amt,
        output pixel_ready, loaded, load_done, pixel_cpr_out, pixel_spr_out
    );
endinterface

// File: rtl/me_mem.sv
// me_mem: loads a raster macroblock + search window into column banks and
// serves the rotated combinational reads that the `me` core expects.
module me_mem #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
) (
    input logic     clk,
    input logic     rst,
    me_mem_if.slave bus
);
    localparam int PORT_WIDTH = MACRO_DIM + 1;
    localparam int NSEG       = SEARCH_DIM / MACRO_DIM;
    localparam int SDEPTH     = NSEG * SEARCH_DIM;
    localparam int CW         = $clog2(MACRO_DIM);
    localparam int BW         = $clog2(PORT_WIDTH);
    localparam int DW         = $clog2(SDEPTH);

    typedef enum logic [1:0] {IDLE, LOAD_CUR, LOAD_SRCH, DONE} state_t;

    state_t          r_state, w_next;
    logic [5:0]      r_row, r_col;
    logic [BW-1:0]   r_bank;
    logic [1:0]      r_seg;
    logic            r_load_done;
    logic [7:0]      r_cur  [MACRO_DIM][MACRO_DIM];
    logic [7:0]      r_srch [PORT_WIDTH][SDEPTH];

    logic            w_accept, w_row_end, w_pic_end;
    logic [5:0]      w_last;
    logic [DW-1:0]   w_widx;
    logic [11:0]     w_ridx;
    logic            w_rok;

    assign w_accept  = bus.pixel_valid && bus.pixel_ready;
    assign w_last    = r_state == LOAD_CUR ? 6'(MACRO_DIM - 1) : 6'(SEARCH_DIM - 1);
    assign w_row_end = w_accept && r_col == w_last;
    assign w_pic_end = w_row_end && r_row == w_last;
    assign w_widx    = DW'(r_seg) * DW'(SEARCH_DIM) + DW'(r_row);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_bank      <= '0;
            r_seg       <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_load_done <= r_state == LOAD_SRCH && w_next == DONE;
            if (w_next != r_state) begin
                r_row  <= '0;
                r_col  <= '0;
                r_bank <= '0;
                r_seg  <= '0;
            end else if (w_row_end) begin
                r_row  <= r_row + 6'd1;
                r_col  <= '0;
                r_bank <= '0;
                r_seg  <= '0;
            end else if (w_accept) begin
                r_col  <= r_col + 6'd1;
                r_bank <= r_bank == BW'(PORT_WIDTH - 1) ? '0 : r_bank + BW'(1);
                r_seg  <= r_seg + 2'(r_bank == BW'(PORT_WIDTH - 1));
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE || r_state == DONE)
            w_next = bus.start_load ? LOAD_CUR : r_state;
        else if (w_pic_end)
            w_next = r_state == LOAD_CUR ? LOAD_SRCH : DONE;
    end

    always_comb begin
        bus.pixel_ready = r_state == LOAD_CUR || r_state == LOAD_SRCH;
        bus.loaded      = r_state == DONE;
        bus.load_done   = r_load_done;
    end

    // The last window column also clears the unused tail banks of its segment row.
    always_ff @(posedge clk) begin
        if (w_accept && r_state == LOAD_CUR)
            r_cur[r_col[CW-1:0]][r_row[CW-1:0]] <= bus.pixel_in;
        for (int k = 0; k < PORT_WIDTH; k++) begin
            if (w_accept && r_state == LOAD_SRCH && BW'(k) == r_bank)
                r_srch[k][w_widx] <= bus.pixel_in;
            else if (w_accept && r_state == LOAD_SRCH && r_col == 6'(SEARCH_DIM - 1) && BW'(k) > r_bank)
                r_srch[k][w_widx] <= '0;
        end
    end

    assign w_ridx = 12'(bus.amt) * 12'(SEARCH_DIM) + 12'(bus.addr);
    assign w_rok  = w_ridx < 12'(SDEPTH) && bus.addr < 6'(SEARCH_DIM);

    for (genvar l = 0; l < MACRO_DIM; l++) begin : g_cpr
        assign bus.pixel_cpr_out[l] = bus.addr < 6'(MACRO_DIM) ? r_cur[l][bus.addr[CW-1:0]] : '0;
    end

    for (genvar l = 0; l < PORT_WIDTH; l++) begin : g_spr
        logic [6:0]    w_sum;
        logic [BW-1:0] w_rbank;
        assign w_sum   = 7'(l) + 7'(bus.amt);
        assign w_rbank = BW'(w_sum % 7'(PORT_WIDTH));
        assign bus.pixel_spr_out[l] = w_rok ? r_srch[w_rbank][w_ridx[DW-1:0]] : '0;
    end
endmodule

// File: tb/tb_me_mem.sv
// tb_me_mem: directed load sequences plus a read-vector table for me_mem.
module tb_me_mem;
    localparam int MD = 16;
    localparam int SD = 48;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    me_mem_if #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) bus();
    me_mem #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {int spr; int amt; int addr; int lane; int exp; int z;} vec_t;
    vec_t vecs[19];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.start_load = 1'b1;
        tick();
        bus.start_load = 1'b0;
    endtask

    function automatic int pix(input int n, input int off);
        if (n < 256) return (n + off) & 255;
        return ((n - 256) / 48 + (n - 256) % 48 + off) & 255;
    endfunction

    task automatic run_load(input int total, input bit tog, input int off, input bit inj,
                            output int cyc, output int rdy_cur, output int dones);
        int  n;
        bit  acc;
        n = 0; cyc = 0; rdy_cur = 0; dones = 0;
        while (n < total && cyc < 20000) begin
            bus.pixel_valid = tog ? (cyc % 2 == 0) : 1'b1;
            bus.pixel_in    = 8'(pix(n, off));
            bus.start_load  = inj && n == 100;
            if (bus.pixel_ready && n < 256) rdy_cur++;
            if (bus.load_done) dones++;
            acc = bus.pixel_ready && bus.pixel_valid;
            @(posedge clk);
            if (acc) n++;
            #1;
            cyc++;
        end
        bus.pixel_valid = 1'b0;
        bus.start_load  = 1'b0;
        chk("load_accepts", n, total);
    endtask

    task automatic apply_table(input int off, input string tag);
        int act, exp;
        foreach (vecs[i]) begin
            bus.amt  = 6'(vecs[i].amt);
            bus.addr = 6'(vecs[i].addr);
            #1;
            act = vecs[i].spr != 0 ? int'(bus.pixel_spr_out[vecs[i].lane]) : int'(bus.pixel_cpr_out[vecs[i].lane]);
            exp = vecs[i].z != 0 ? 0 : (vecs[i].exp + off) & 255;
            chk($sformatf("%s_vec%0d", tag, i), act, exp);
        end
    endtask

    initial begin
        int cyc, rc, dn;
        vecs = '{
            '{0, 0, 5, 0, 80, 0},  '{0, 0, 5, 7, 87, 0},   '{0, 0, 5, 15, 95, 0},
            '{0, 0, 0, 15, 15, 0}, '{0, 0, 16, 3, 0, 1},   '{1, 0, 3, 0, 3, 0},
            '{1, 0, 3, 16, 19, 0}, '{1, 1, 3, 0, 21, 0},   '{1, 1, 3, 15, 36, 0},
            '{1, 1, 3, 16, 20, 0}, '{1, 2, 10, 0, 46, 0},  '{1, 2, 10, 11, 57, 0},
            '{1, 2, 10, 12, 0, 1}, '{1, 2, 10, 14, 0, 1},  '{1, 2, 10, 15, 44, 0},
            '{1, 3, 0, 0, 0, 1},   '{1, 0, 48, 0, 0, 1},   '{1, 0, 47, 16, 63, 0},
            '{1, 3, 5, 16, 0, 1}
        };
        rst = 1'b1;
        bus.start_load = 1'b0; bus.pixel_valid = 1'b0; bus.pixel_in = '0;
        bus.addr = '0; bus.amt = '0;
        tick(); tick();
        chk("reset_ready", int'(bus.pixel_ready), 0);
        chk("reset_loaded", int'(bus.loaded), 0);
        chk("reset_load_done", int'(bus.load_done), 0);
        rst = 1'b0;
        tick();
        start_pulse();
        chk("start_ready", int'(bus.pixel_ready), 1);
        run_load(1256, 1'b0, 0, 1'b0, cyc, rc, dn);
        rst = 1'b1;
        tick();
        chk("rst_mid_ready", int'(bus.pixel_ready), 0);
        chk("rst_mid_loaded", int'(bus.loaded), 0);
        rst = 1'b0;
        tick();
        chk("rst_idle_ready", int'(bus.pixel_ready), 0);

        start_pulse();
        run_load(2560, 1'b0, 0, 1'b1, cyc, rc, dn);
        chk("cont_cycles", cyc, 2560);
        chk("cont_cur_ready_cycles", rc, 256);
        chk("cont_early_done", dn, 0);
        chk("cont_load_done", int'(bus.load_done), 1);
        chk("cont_loaded", int'(bus.loaded), 1);
        chk("cont_ready_off", int'(bus.pixel_ready), 0);
        tick();
        chk("cont_done_fall", int'(bus.load_done), 0);
        chk("cont_loaded_hold", int'(bus.loaded), 1);
        apply_table(0, "cont");

        start_pulse();
        chk("reload_loaded_drop", int'(bus.loaded), 0);
        chk("reload_ready", int'(bus.pixel_ready), 1);
        run_load(2560, 1'b1, 100, 1'b0, cyc, rc, dn);
        chk("tog_cycles", cyc, 5119);
        chk("tog_early_done", dn, 0);
        chk("tog_load_done", int'(bus.load_done), 1);
        chk("tog_loaded", int'(bus.loaded), 1);
        tick();
        apply_table(100, "reload");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
